zap_fetch_queue: RTL and testbench
==================================

// Module: zap_fetch_queue
// PURPOSE
//  Fetch front end on the far side of the writeback PC interface: consumes the
//  writeback PC, issues instruction-bus reads and raises the code stall that
//  writeback uses to freeze or shelve its PC. Fetched words sit in a small
//  queue that feeds decode; clears flush the queue and drop stale bus replies.
// PARAMETERS
//  DEPTH      2   queue entries; power of 2, >= 2
// PORTS
//  i_clk                 in   1   core clock
//  i_reset               in   1   synchronous, active-high reset
//  i_pc                  in   32  PC to fetch (writeback o_pc)
//  i_cpsr_t              in   1   1 = Thumb state (affects PC+8 only)
//  i_clear               in   1   OR of writeback/ALU/decode clears
//  i_stall               in   1   decode cannot accept this cycle
//  o_instr_req           out  1   bus request (Wishbone-classic style)
//  o_instr_addr          out  32  bus address, {i_pc[31:2],2'b00}
//  i_instr_ack           in   1   bus acknowledge, data valid
//  i_instr_err           in   1   bus error, qualified by i_instr_ack
//  i_instr_data          in   32  bus read data
//  o_code_stall          out  1   PC must hold (writeback i_code_stall)
//  o_valid               out  1   queue head valid
//  o_instruction         out  32  head word (0 on abort)
//  o_pc_ff               out  32  head fetch PC
//  o_pc_plus_8_ff        out  32  head PC+8 (ARM) / PC+4 (Thumb)
//  o_instr_abort         out  1   head entry faulted on bus
// BEHAVIOUR
//  - Reset: queue empty, state IDLE, o_valid=0, o_instr_req=0, all data out 0,
//    o_code_stall=1. Reset wins over every other input in the same cycle.
//  - States: IDLE, WAIT, DISCARD.
//    IDLE: o_instr_req=1 iff queue not full -> WAIT same cycle (req is comb.).
//    WAIT: req held, address = i_pc. ack & !i_clear -> push entry, to IDLE.
//      ack & i_clear -> drop reply, no push, to IDLE. !ack & i_clear ->
//      DISCARD (req stays high; bus transfers are not abortable).
//    DISCARD: req held on old address; on ack drop reply -> IDLE. Further
//      i_clear in DISCARD has no extra effect.
//  - Address latched into a hold register on WAIT entry so it is stable while
//    req is high, even if i_pc changes.
//  - o_code_stall = !(state==WAIT & i_instr_ack & !i_clear). Exactly one
//    PC advance per accepted word; stall high in IDLE, DISCARD, when full.
//  - Entry push: {data or 0, PC, PC+(T?4:8), abort=i_instr_err}; 32-bit add
//    wraps mod 2^32 (PC 0xFFFFFFFC ARM -> PC+8 = 0x00000004).
//  - Pop when o_valid & !i_stall. Push and pop same cycle: count unchanged,
//    legal when full (push only possible if not full at request start; full
//    blocks new requests only, never an in-flight reply).
//  - Count width $clog2(DEPTH)+1; pointers wrap mod DEPTH.
//  - i_clear: queue emptied next cycle (count, pointers 0, o_valid=0), any
//    same-cycle pop/push discarded. Head outputs registered from queue RAM.
//  - Abort entries flow in order; block never retries on error.
// TESTING
//  1 Reset mid-WAIT (req high, no ack) -> next cycle req=0, valid=0,
//    stall=1; following cycle req=1 with addr=i_pc.
//  2 i_pc=0x100, ack same cycle, ARM -> next cycle valid=1, pc_ff=0x100,
//    pc_plus_8=0x108; code_stall low exactly in ack cycle.
//  3 i_stall held, DEPTH=2, 3 acks offered -> 2 entries queued, req=0
//    after full; release stall -> pop order 0x100,0x104, then req resumes.
//  4 Clear while WAIT, ack 3 cycles later with 0xDEADBEEF -> DISCARD,
//    reply dropped, valid stays 0, next req uses new i_pc=0x18.
//  5 ack & err at PC=0x200, Thumb -> entry abort=1, instruction=0,
//    pc_plus_8=0x204.
//  6 Push+pop same cycle with queue full -> count stays 2, order kept;
//    PC=0xFFFFFFFC ARM -> pc_plus_8=0x00000004.

Source files
------------

// File: rtl/zap_fetch_queue.sv
// Fetch front end: issues instruction-bus reads for the writeback PC, raises the
// code stall, and buffers fetched words in a small queue in front of decode.
module zap_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc,
  input  logic        i_cpsr_t,
  input  logic        i_clear,
  input  logic        i_stall,
  output logic        o_instr_req,
  output logic [31:0] o_instr_addr,
  input  logic        i_instr_ack,
  input  logic        i_instr_err,
  input  logic [31:0] i_instr_data,
  output logic        o_code_stall,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_pc_plus_8_ff,
  output logic        o_instr_abort
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state_r;
  logic          rst_hold_r;
  logic [31:0]   hold_pc_r;
  logic          hold_t_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;

  logic [31:0] mem_instr_r [DEPTH];
  logic [31:0] mem_pc_r    [DEPTH];
  logic [31:0] mem_pc8_r   [DEPTH];
  logic        mem_abort_r [DEPTH];

  logic          full_s;
  logic          live_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   fetch_pc_s;
  logic          fetch_t_s;
  logic [31:0]   push_instr_s;
  logic [31:0]   push_pc8_s;
  logic [CW-1:0] count_after_pop_s;
  logic [PW-1:0] rd_ptr_nxt_s;

  // Bus handshake and queue control decode; IDLE with room acts as a live request cycle.
  always_comb begin
    full_s            = (count_r == CW'(DEPTH));
    live_s            = 1'b0;
    o_instr_req       = 1'b0;
    o_instr_addr      = 32'd0;
    fetch_pc_s        = hold_pc_r;
    fetch_t_s         = hold_t_r;
    if (state_r == IDLE) begin
      fetch_pc_s = i_pc;
      fetch_t_s  = i_cpsr_t;
    end else begin
      fetch_pc_s = hold_pc_r;
      fetch_t_s  = hold_t_r;
    end
    if (!i_reset && !rst_hold_r) begin
      live_s      = ((state_r == IDLE) && !full_s) || (state_r == WAIT);
      o_instr_req = live_s || (state_r == DISCARD);
    end else begin
      live_s      = 1'b0;
      o_instr_req = 1'b0;
    end
    o_instr_addr      = {fetch_pc_s[31:2], 2'b00};
    push_s            = live_s && i_instr_ack && !i_clear;
    o_code_stall      = !push_s;
    pop_s             = o_valid && !i_stall;
    push_instr_s      = i_instr_err ? 32'd0 : i_instr_data;
    push_pc8_s        = fetch_pc_s + (fetch_t_s ? 32'd4 : 32'd8);
    count_after_pop_s = count_r - CW'(pop_s);
    rd_ptr_nxt_s      = rd_ptr_r + PW'(pop_s);
  end

  // Request FSM; a started bus cycle always runs to its ack, dropped if a clear intervened.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= IDLE;
      rst_hold_r <= 1'b1;
      hold_pc_r  <= 32'd0;
      hold_t_r   <= 1'b0;
    end else begin
      rst_hold_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (live_s && !i_instr_ack) begin
            state_r   <= i_clear ? DISCARD : WAIT;
            hold_pc_r <= i_pc;
            hold_t_r  <= i_cpsr_t;
          end
        end
        WAIT: begin
          if (i_instr_ack)  state_r <= IDLE;
          else if (i_clear) state_r <= DISCARD;
          else              state_r <= WAIT;
        end
        DISCARD: begin
          if (i_instr_ack) state_r <= IDLE;
          else             state_r <= DISCARD;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Queue storage; no reset needed since validity is tracked by the count.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_instr_r[wr_ptr_r] <= push_instr_s;
      mem_pc_r[wr_ptr_r]    <= fetch_pc_s;
      mem_pc8_r[wr_ptr_r]   <= push_pc8_s;
      mem_abort_r[wr_ptr_r] <= i_instr_err;
    end
  end

  // Queue pointers and registered head; a word arriving into an empty queue bypasses the RAM.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      count_r        <= '0;
      rd_ptr_r       <= '0;
      wr_ptr_r       <= '0;
      o_valid        <= 1'b0;
      o_instruction  <= 32'd0;
      o_pc_ff        <= 32'd0;
      o_pc_plus_8_ff <= 32'd0;
      o_instr_abort  <= 1'b0;
    end else begin
      count_r  <= count_after_pop_s + CW'(push_s);
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_r + PW'(push_s);
      if (count_after_pop_s != '0) begin
        o_valid        <= 1'b1;
        o_instruction  <= mem_instr_r[rd_ptr_nxt_s];
        o_pc_ff        <= mem_pc_r[rd_ptr_nxt_s];
        o_pc_plus_8_ff <= mem_pc8_r[rd_ptr_nxt_s];
        o_instr_abort  <= mem_abort_r[rd_ptr_nxt_s];
      end else if (push_s) begin
        o_valid        <= 1'b1;
        o_instruction  <= push_instr_s;
        o_pc_ff        <= fetch_pc_s;
        o_pc_plus_8_ff <= push_pc8_s;
        o_instr_abort  <= i_instr_err;
      end else begin
        o_valid        <= 1'b0;
        o_instruction  <= 32'd0;
        o_pc_ff        <= 32'd0;
        o_pc_plus_8_ff <= 32'd0;
        o_instr_abort  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zap_fetch_queue.sv
// Bench for zap_fetch_queue: directed scenarios plus random traffic, all checked
// against a transaction-level model (fetch queue + in-flight request tracking).
module tb_zap_fetch_queue;

  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_pc = 32'd0;
  logic        i_cpsr_t = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_stall = 1'b0;
  logic        o_instr_req;
  logic [31:0] o_instr_addr;
  logic        i_instr_ack = 1'b0;
  logic        i_instr_err = 1'b0;
  logic [31:0] i_instr_data = 32'd0;
  logic        o_code_stall;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_ff;
  logic [31:0] o_pc_plus_8_ff;
  logic        o_instr_abort;

  zap_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc(i_pc), .i_cpsr_t(i_cpsr_t),
    .i_clear(i_clear), .i_stall(i_stall), .o_instr_req(o_instr_req),
    .o_instr_addr(o_instr_addr), .i_instr_ack(i_instr_ack),
    .i_instr_err(i_instr_err), .i_instr_data(i_instr_data),
    .o_code_stall(o_code_stall), .o_valid(o_valid), .o_instruction(o_instruction),
    .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_instr_abort(o_instr_abort)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        abort;
  } entry_t;

  entry_t      q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_pc = 32'd0;
  bit          m_rst_gap = 1'b1;
  bit          m_inflight = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_hold_pc = 32'd0;
  bit          m_hold_t = 1'b0;
  bit          p_req;
  bit          p_live;
  bit          p_stall;
  logic [31:0] p_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    entry_t e;
    bit     accept;
    bit     t;
    if (i_reset) begin
      q.delete();
      m_inflight = 1'b0;
      m_drop     = 1'b0;
      m_rst_gap  = 1'b1;
    end else begin
      accept  = p_live && i_instr_ack && !i_clear;
      e.pc    = m_inflight ? m_hold_pc : i_pc;
      t       = m_inflight ? m_hold_t : i_cpsr_t;
      e.pc8   = e.pc + (t ? 32'd4 : 32'd8);
      e.instr = i_instr_err ? 32'd0 : i_instr_data;
      e.abort = i_instr_err;
      if (i_clear) q.delete();
      else begin
        if (q.size() > 0 && !i_stall) void'(q.pop_front());
        if (accept) q.push_back(e);
      end
      if (p_req) begin
        if (i_instr_ack) begin
          m_inflight = 1'b0;
          m_drop     = 1'b0;
        end else if (!m_inflight) begin
          m_inflight = 1'b1;
          m_hold_pc  = i_pc;
          m_hold_t   = i_cpsr_t;
          m_drop     = i_clear;
        end else if (i_clear) begin
          m_drop = 1'b1;
        end
      end
      if (accept) cur_pc = cur_pc + 32'd4;
      m_rst_gap = 1'b0;
    end
  endtask

  // One clock cycle: offer ack only when a request is expected, check, then advance the model.
  task automatic step(input bit want_ack);
    i_pc   = cur_pc;
    p_req  = !i_reset && !m_rst_gap && (m_inflight || q.size() < DEPTH);
    p_live = p_req && !m_drop;
    p_addr = (m_inflight ? m_hold_pc : i_pc) & 32'hFFFF_FFFC;
    i_instr_ack = want_ack && p_req;
    p_stall = !(p_live && i_instr_ack && !i_clear);
    #1;
    check_eq("req", o_instr_req, p_req);
    if (p_req) check_eq("addr", o_instr_addr, p_addr);
    check_eq("code_stall", o_code_stall, p_stall);
    check_eq("valid", o_valid, q.size() > 0);
    if (q.size() > 0) begin
      check_eq("instr", o_instruction, q[0].instr);
      check_eq("pc_ff", o_pc_ff, q[0].pc);
      check_eq("pc_plus_8", o_pc_plus_8_ff, q[0].pc8);
      check_eq("abort", o_instr_abort, q[0].abort);
    end
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
  endtask

  // Clear with an ack so any bus cycle finishes; leaves the queue empty and idle.
  task automatic flush();
    i_clear = 1'b1;
    step(1'b1);
    i_clear = 1'b0;
    step(1'b1);
    i_clear = 1'b1;
    step(1'b1);
    i_clear = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    model_update();
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_req", o_instr_req, 1'b0);
    check_eq("rst_stall", o_code_stall, 1'b1);
    check_eq("rst_instr", o_instruction, 32'd0);
    check_eq("rst_pc", o_pc_ff, 32'd0);
    check_eq("rst_pc8", o_pc_plus_8_ff, 32'd0);
    check_eq("rst_abort", o_instr_abort, 1'b0);
    step(1'b0);

    // Reset in the middle of an outstanding request
    cur_pc = 32'h80;
    step(1'b0);
    step(1'b0);
    i_reset = 1'b1;
    step(1'b0);
    i_reset = 1'b0;
    cur_pc = 32'h90;
    step(1'b0);
    #1;
    check_eq("t1_req_resume", o_instr_req, 1'b1);
    check_eq("t1_addr", o_instr_addr, 32'h90);
    flush();

    // Single ARM fetch, ack in the request cycle
    cur_pc = 32'h100;
    i_instr_data = 32'hE3A0_0001;
    step(1'b1);
    check_eq("t2_valid", o_valid, 1'b1);
    check_eq("t2_pc", o_pc_ff, 32'h100);
    check_eq("t2_pc8", o_pc_plus_8_ff, 32'h108);
    flush();

    // Queue fills under decode stall; stall release pops in order
    i_stall = 1'b1;
    cur_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      i_instr_data = $urandom;
      step(1'b1);
    end
    check_eq("t3_full_req", o_instr_req, 1'b0);
    check_eq("t3_head0", o_pc_ff, 32'h100);
    i_stall = 1'b0;
    step(1'b0);
    check_eq("t3_head1", o_pc_ff, 32'h104);
    step(1'b0);
    flush();

    // Clear during WAIT; late reply is discarded
    cur_pc = 32'h40;
    step(1'b0);
    i_clear = 1'b1;
    cur_pc = 32'h18;
    step(1'b0);
    i_clear = 1'b0;
    step(1'b0);
    step(1'b0);
    i_instr_data = 32'hDEAD_BEEF;
    step(1'b1);
    #1;
    check_eq("t4_valid", o_valid, 1'b0);
    check_eq("t4_new_addr", o_instr_addr, 32'h18);
    check_eq("t4_req", o_instr_req, 1'b1);
    flush();

    // Bus error in Thumb state
    i_cpsr_t = 1'b1;
    cur_pc = 32'h200;
    i_instr_err = 1'b1;
    i_instr_data = 32'h1234_5678;
    step(1'b1);
    i_instr_err = 1'b0;
    check_eq("t5_abort", o_instr_abort, 1'b1);
    check_eq("t5_instr", o_instruction, 32'd0);
    check_eq("t5_pc8", o_pc_plus_8_ff, 32'h204);
    i_cpsr_t = 1'b0;
    flush();

    // PC wrap and simultaneous push and pop
    i_stall = 1'b1;
    cur_pc = 32'hFFFF_FFFC;
    step(1'b1);
    check_eq("t6_pc8_wrap", o_pc_plus_8_ff, 32'h0000_0004);
    i_stall = 1'b0;
    step(1'b1);
    check_eq("t6_valid", o_valid, 1'b1);
    check_eq("t6_next_pc", o_pc_ff, 32'h0000_0000);
    flush();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      i_reset      = ($urandom_range(0, 199) == 0);
      i_clear      = ($urandom_range(0, 9) == 0);
      i_stall      = ($urandom_range(0, 2) == 0);
      i_instr_err  = ($urandom_range(0, 7) == 0);
      i_instr_data = $urandom;
      if ($urandom_range(0, 15) == 0) i_cpsr_t = ~i_cpsr_t;
      if (i_clear) cur_pc = {$urandom, 1'b0} & 32'hFFFF_FFFE;
      step($urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
